// File: rtl/req_priority_encoder.sv
// Sequential N-to-log2(N) priority encoder with valid/ready output.
// Define RR_PRIORITY_EN for round-robin priority instead of fixed.
module req_priority_encoder #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             clear_i,
  input  logic             ready_i,
  output logic [IDX_W-1:0] code_o,
  output logic             valid_o,
  output logic [N_REQ-1:0] pending_o,
  output logic             merge_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [N_REQ-1:0]   pending_q;
  logic [N_REQ-1:0]   next_pend;
  logic [N_REQ-1:0]   ack_mask;
  logic [N_REQ-1:0]   hit;
  logic [IDX_W-1:0]   code_q;
  logic [IDX_W-1:0]   code_d;
  logic               valid_q;
  logic               valid_d;
  logic               merge_q;
  logic               merge_d;
  logic               xfer;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  // A flush cancels any handshake in the same cycle.
  assign xfer = valid_q & ready_i & ~clear_i;

  // Retire the granted bit; a fresh request on it re-arms it.
  always_comb begin
    ack_mask = '0;
    if (xfer) begin
      ack_mask = N_REQ'(1) << code_q;
    end
    next_pend = '0;
    if (!clear_i) begin
      next_pend = (pending_q & ~ack_mask) | req_i;
    end
    hit     = req_i & pending_q & ~ack_mask;
    merge_d = ~clear_i & (|hit);
  end

`ifdef RR_PRIORITY_EN
  logic [IDX_W-1:0] ptr_q;

  // After granting k, k becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = code_q - IDX_W'(1);
    end
  end

  // Round-robin search pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(N_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr_d = IDX_W'(N_REQ - 1);
`endif

  // Search down from ptr_d with wrap; ptr_d itself wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel_idx = '0;
    sel_any = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr_d - IDX_W'(i);
      if (next_pend[cand]) begin
        sel_idx = cand;
        sel_any = 1'b1;
      end
    end
  end

  // Grant FSM: load on entry, hold while stalled.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    if (clear_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_any) begin
            code_d  = sel_idx;
            valid_d = 1'b1;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            if (sel_any) begin
              code_d  = sel_idx;
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      merge_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= next_pend;
      code_q    <= code_d;
      valid_q   <= valid_d;
      merge_q   <= merge_d;
    end
  end

  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign pending_o = pending_q;
  assign merge_o   = merge_q;

endmodule
